// File: rtl/final_vga_board.sv
`default_nettype none
// ============================================================================
//  Module      : final_vga_board
//  Description : VGA raster generator that draws a GRID_N x GRID_N game board.
//                A modulo-CLK_DIV divider produces the pixel enable. Horizontal
//                and vertical counters scan the frame. Incremental per-axis
//                trackers give the cell column/row and the in-cell offset, so
//                the pixel path uses no divider or multiplier. The board and
//                the cursor are snapshotted once per frame at the start of
//                vertical blanking. Every frame is drawn from one consistent
//                snapshot.
//
//  Ports       : clk         system clock
//                rst_n       asynchronous active-low reset
//                board       2 bits per cell, cell i = row*GRID_N+col
//                            00 empty, 01 player1, 10 player2, 11 win
//                cursor      [7:4] row, [3:0] col of the highlighted cell
//                hsync/vsync sync pulses, at SYNC_POL during the sync interval
//                red/green/blue  4-bit colour, 0 outside the active region
//                video_on    high for active-region pixels
//                frame_start one-clk pulse on the snapshot pixel cycle
//
//  Revision    : 1.0  initial release
// ============================================================================
module final_vga_board #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 4,
    parameter logic SYNC_POL = 1'b0,
    parameter int   GRID_N   = 3,
    parameter int   CELL     = 96,
    parameter int   LINE     = 4,
    parameter int   X0       = 176,
    parameter int   Y0       = 96
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2*GRID_N*GRID_N-1:0]   board,
    input  logic [7:0]                   cursor,
    output logic                         hsync,
    output logic                         vsync,
    output logic [3:0]                   red,
    output logic [3:0]                   green,
    output logic [3:0]                   blue,
    output logic                         video_on,
    output logic                         frame_start
);

    // ------------------------------------------------------------------
    // Derived sizes and typed constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OW      = (CELL > 1) ? $clog2(CELL) : 1;

    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_BOARD_BEG  = HW'(X0);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_BOARD_BEG  = VW'(Y0);

    // In-cell offset thresholds. The last cell on each axis also carries
    // the closing grid line, so its interior ends LINE pixels early.
    localparam logic [OW-1:0] OFF_LAST     = OW'(CELL - 1);
    localparam logic [OW-1:0] OFF_LINE     = OW'(LINE);
    localparam logic [OW-1:0] OFF_NEAR     = OW'(LINE + 2);
    localparam logic [OW-1:0] OFF_FAR      = OW'(CELL - 2);
    localparam logic [OW-1:0] OFF_EDGE     = OW'(CELL - LINE);
    localparam logic [OW-1:0] OFF_EDGE_FAR = OW'(CELL - LINE - 2);

    localparam logic [3:0]    IDX_LAST     = 4'(GRID_N - 1);

    localparam logic          XIN_RST      = (X0 == 0);
    localparam logic          YIN_RST      = (Y0 == 0);

    localparam logic [11:0]   C_BLACK      = 12'h000;
    localparam logic [11:0]   C_BACK       = 12'h111;
    localparam logic [11:0]   C_GRID       = 12'hFFF;
    localparam logic [11:0]   C_CURSOR     = 12'hFF0;
    localparam logic [11:0]   C_P1         = 12'hF00;
    localparam logic [11:0]   C_P2         = 12'h00F;
    localparam logic [11:0]   C_WIN        = 12'h0F0;

    // ------------------------------------------------------------------
    // Pixel-enable divider
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q, div_d;
    logic          pix_en;

    assign pix_en = (div_q == DIV_LAST);

    always_comb begin
        div_d = pix_en ? '0 : div_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Scan counters and per-axis board trackers
    // ------------------------------------------------------------------
    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          xin_q, xin_d;      // hc lies inside the board columns
    logic          yin_q, yin_d;      // vc lies inside the board rows
    logic [3:0]    col_q, col_d;
    logic [3:0]    row_q, row_d;
    logic [OW-1:0] xoff_q, xoff_d;
    logic [OW-1:0] yoff_q, yoff_d;

    // The trackers are kept in step with the counters by looking at the
    // counter's next value. This keeps col/row/offset aligned with hc/vc
    // and avoids any division on the pixel path.
    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        xin_d  = xin_q;
        yin_d  = yin_q;
        col_d  = col_q;
        row_d  = row_q;
        xoff_d = xoff_q;
        yoff_d = yoff_q;

        if (pix_en) begin
            hc_d = (hc_q == H_LAST) ? '0 : hc_q + 1'b1;

            if (hc_d == H_BOARD_BEG) begin
                xin_d  = 1'b1;
                col_d  = '0;
                xoff_d = '0;
            end else if (xin_q) begin
                if (xoff_q == OFF_LAST) begin
                    xoff_d = '0;
                    if (col_q == IDX_LAST) begin
                        xin_d = 1'b0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    xoff_d = xoff_q + 1'b1;
                end
            end

            if (hc_q == H_LAST) begin
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;

                if (vc_d == V_BOARD_BEG) begin
                    yin_d  = 1'b1;
                    row_d  = '0;
                    yoff_d = '0;
                end else if (yin_q) begin
                    if (yoff_q == OFF_LAST) begin
                        yoff_d = '0;
                        if (row_q == IDX_LAST) begin
                            yin_d = 1'b0;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        yoff_d = yoff_q + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot of board and cursor
    // ------------------------------------------------------------------
    logic                       snap;
    logic [2*GRID_N*GRID_N-1:0] board_q;
    logic [3:0]                 cur_row_q;
    logic [3:0]                 cur_col_q;

    // First pixel of vertical blanking: nothing visible is being drawn, so
    // a new snapshot can never tear the picture.
    assign snap        = pix_en && (hc_q == '0) && (vc_q == V_ACT_END);
    assign frame_start = snap;

    // ------------------------------------------------------------------
    // Pixel colour for the current (hc, vc)
    // ------------------------------------------------------------------
    logic        active;
    logic        in_board;
    logic        hs_act;
    logic        vs_act;
    logic        x_line, y_line;
    logic        x_near, y_near;
    logic        cur_hit;
    logic [1:0]  cell_state;
    logic [11:0] rgb_d;

    assign active   = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
    assign in_board = active && xin_q && yin_q;
    assign hs_act   = (hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END);
    assign vs_act   = (vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END);

    assign x_line = (xoff_q < OFF_LINE) ||
                    ((col_q == IDX_LAST) && (xoff_q >= OFF_EDGE));
    assign y_line = (yoff_q < OFF_LINE) ||
                    ((row_q == IDX_LAST) && (yoff_q >= OFF_EDGE));

    // Two-pixel band just inside the surrounding grid lines.
    assign x_near = (xoff_q < OFF_NEAR) ||
                    ((col_q == IDX_LAST) ? (xoff_q >= OFF_EDGE_FAR)
                                         : (xoff_q >= OFF_FAR));
    assign y_near = (yoff_q < OFF_NEAR) ||
                    ((row_q == IDX_LAST) ? (yoff_q >= OFF_EDGE_FAR)
                                         : (yoff_q >= OFF_FAR));

    // row/col never exceed GRID_N-1, so an out-of-range cursor never hits.
    assign cur_hit = (cur_row_q == row_q) && (cur_col_q == col_q);

    // Cell select by comparing against every (row, col) pair; all indices
    // into the shadow board are constants.
    always_comb begin
        cell_state = 2'b00;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                if ((row_q == 4'(r)) && (col_q == 4'(c))) begin
                    cell_state = board_q[2*(r*GRID_N+c) +: 2];
                end
            end
        end
    end

    always_comb begin
        rgb_d = C_BLACK;
        if (!active) begin
            rgb_d = C_BLACK;
        end else if (!in_board) begin
            rgb_d = C_BACK;
        end else if (x_line || y_line) begin
            rgb_d = C_GRID;
        end else if (cur_hit && (x_near || y_near)) begin
            rgb_d = C_CURSOR;
        end else begin
            case (cell_state)
                2'b01:   rgb_d = C_P1;
                2'b10:   rgb_d = C_P2;
                2'b11:   rgb_d = C_WIN;
                default: rgb_d = C_BLACK;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic        hsync_q;
    logic        vsync_q;
    logic        video_on_q;
    logic [11:0] rgb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            hc_q       <= '0;
            vc_q       <= '0;
            xin_q      <= XIN_RST;
            yin_q      <= YIN_RST;
            col_q      <= '0;
            row_q      <= '0;
            xoff_q     <= '0;
            yoff_q     <= '0;
            board_q    <= '0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            video_on_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            div_q  <= div_d;
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            xin_q  <= xin_d;
            yin_q  <= yin_d;
            col_q  <= col_d;
            row_q  <= row_d;
            xoff_q <= xoff_d;
            yoff_q <= yoff_d;

            if (snap) begin
                board_q   <= board;
                cur_row_q <= cursor[7:4];
                cur_col_q <= cursor[3:0];
            end

            // Outputs lag the counters by exactly one pixel.
            if (pix_en) begin
                hsync_q    <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync_q    <= vs_act ? SYNC_POL : ~SYNC_POL;
                video_on_q <= active;
                rgb_q      <= rgb_d;
            end
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;
    assign red      = rgb_q[11:8];
    assign green    = rgb_q[7:4];
    assign blue     = rgb_q[3:0];

endmodule
`default_nettype wire
